// File: rtl/hex_keypad.sv
// hex_keypad: scans a 4x4 keypad, debounces whole frames and shifts accepted key codes into a hex digit register
module hex_keypad #(
    parameter int P_TICK_DIV = 250000,
    parameter int P_DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  iCol,
    input  logic        iRe,
    input  logic        iClr,
    output logic [3:0]  oRow,
    output logic [31:0] oData,
    output logic [3:0]  oKey,
    output logic        oValid
);
    localparam int DW = $clog2(P_TICK_DIV);
    localparam int CW = $clog2(P_DEBOUNCE + 1);
    localparam logic [CW-1:0] DEB = CW'(P_DEBOUNCE);

    typedef enum logic [1:0] {IDLE, CAND, HELD} state_t;

    logic [3:0]    col_s1, col_s2;
    logic [DW-1:0] div_q;
    logic [1:0]    r_q;
    logic [15:0]   frame_q, mask;
    logic          tick, frame_done, empty, single, accept;
    logic [3:0]    key;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]    cand_q, cand_d;

    assign tick = div_q == DW'(P_TICK_DIV - 1);
    assign frame_done = tick && r_q == 2'd3;
    assign cnt_inc = cnt_q + CW'(1);

    // two-flop synchronizer; idles high so a reset never looks like a press
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_s1 <= 4'hf;
            col_s2 <= 4'hf;
        end else begin
            col_s1 <= iCol;
            col_s2 <= col_s1;
        end
    end

    // tick divider, row rotation and per-row sampling at the end of each row window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q   <= '0;
            r_q     <= '0;
            oRow    <= 4'b1110;
            frame_q <= '0;
        end else if (tick) begin
            div_q   <= '0;
            r_q     <= r_q + 2'd1;
            oRow    <= {oRow[2:0], oRow[3]};
            frame_q[{r_q, 2'b00} +: 4] <= ~col_s2;
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

    // full-frame mask includes the row sample being taken this cycle
    always_comb begin
        mask = frame_q;
        mask[{r_q, 2'b00} +: 4] = ~col_s2;
        key = '0;
        for (int i = 0; i < 16; i++) if (mask[i]) key = 4'(i);
        empty = mask == '0;
        single = !empty && (mask & (mask - 16'd1)) == '0;
    end

    // debounce state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

    // debounce next state; only frame-complete ticks move the machine
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        accept  = 1'b0;
        if (frame_done) begin
            case (state_q)
                IDLE: if (single) begin
                    cand_d = key;
                    cnt_d  = CW'(1);
                    if (P_DEBOUNCE == 1) begin
                        accept  = 1'b1;
                        state_d = HELD;
                        cnt_d   = '0;
                    end else state_d = CAND;
                end
                CAND: if (single && key == cand_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DEB) begin
                        accept  = 1'b1;
                        state_d = HELD;
                        cnt_d   = '0;
                    end
                end else if (single) begin
                    cand_d = key;
                    cnt_d  = CW'(1);
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
                HELD: if (empty) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DEB) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else cnt_d = '0;
                default: state_d = IDLE;
            endcase
        end
    end

    // CPU-visible registers; an accept wins over a same-cycle clear or read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oData  <= '0;
            oKey   <= '0;
            oValid <= 1'b0;
        end else begin
            oData  <= accept ? {iClr ? 28'd0 : oData[27:0], cand_d} : iClr ? 32'd0 : oData;
            oKey   <= accept ? cand_d : oKey;
            oValid <= accept | (oValid & ~iRe);
        end
    end
endmodule

// File: doc/hex_keypad.md
# hex_keypad

Memory-mapped input peripheral that scans a 4x4 hex keypad, debounces it and shifts each accepted key code as a hex digit into a 32-bit value the CPU reads. It is the input counterpart of the 8-digit hex seven-segment display: digits typed here land in the same nibble layout the display shows, with the newest digit in bits [3:0]. It sits on the peripheral bus beside the display driver.

## Interface
- P_TICK_DIV, 250000: clk cycles per scan tick; must be >= 4.
- P_DEBOUNCE, 4: consecutive identical full frames needed to accept a press or a release; must be >= 1.
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low.
- iCol  input  4  keypad columns, active-low, pulled up, asynchronous to clk.
- iRe  input  1  CPU read strobe, one cycle; clears oValid.
- iClr  input  1  one-cycle strobe; clears oData.
- oRow  output  4  row drive, active-low; exactly one bit low at all times.
- oData  output  32  accumulated hex digits, newest in [3:0].
- oKey  output  4  code of the last accepted key.
- oValid  output  1  a key was accepted since the last iRe.

## Operation
- Synchronizer: iCol passes through two flops. Only the synchronized value is used.
- Tick divider: counts 0..P_TICK_DIV-1 and wraps. The tick pulse is one cycle wide, at count P_TICK_DIV-1.
- Scan: row index r (0..3) drives oRow = ~(1<<r).
- On each tick, the module samples pressed = ~colSync into frame bits [4r+3:4r], then r increments and wraps 3->0.
- The tick at r=3 completes a frame.
- Key code = 4*row + col. Example: row 1, col 2 gives code 6.
- Frame classification uses the full 16-bit pressed mask, including the row-3 sample taken on the same tick:
  - EMPTY: 0 bits set.
  - SINGLE(k): exactly 1 bit set, at index k.
  - MULTI: 2 or more bits set.
- The FSM below evaluates only on frame-complete ticks. cnt is a frame counter, cand is the candidate key code.
- IDLE:
  - SINGLE(k): cand=k, cnt=1. If P_DEBOUNCE==1, accept and go to HELD; otherwise go to CAND.
  - EMPTY or MULTI: stay in IDLE.
- CAND:
  - SINGLE(cand): cnt++. When cnt reaches P_DEBOUNCE, accept and go to HELD.
  - SINGLE(k!=cand): cand=k, cnt=1, stay in CAND.
  - EMPTY or MULTI: go to IDLE, cnt=0.
- HELD:
  - EMPTY: cnt++. When cnt reaches P_DEBOUNCE, go to IDLE.
  - Any non-EMPTY frame: cnt=0, stay in HELD. Holding or rolling to another key never produces a second accept.
  - On entry to HELD, cnt=0.
- Accept:
  - oData <= {oData[27:0], cand}; the oldest digit is discarded.
  - oKey <= cand.
  - oValid <= 1.
- iRe: oValid <= 0. If iRe and an accept occur in the same cycle, oValid = 1 (accept wins).
- iClr: oData <= 0. If iClr and an accept occur in the same cycle, oData = {28'b0, cand}. iClr does not affect oKey, oValid or the FSM.

## Timing
- Reset values:
  - oRow = 4'b1110, r = 0, divider = 0, synchronizer flops all 1.
  - oData = 0, oKey = 0, oValid = 0.
  - FSM in IDLE, cnt = 0, cand = 0, frame bits = 0.
- A reset asserted mid-frame or mid-hold returns every item above to its reset value immediately. A key still held after reset release is accepted again after P_DEBOUNCE frames.
- oRow changes the cycle after a tick, so each row is driven for exactly P_TICK_DIV cycles. The sample is taken at the end of that window.
- A frame lasts 4*P_TICK_DIV cycles.
- All outputs are registered. oData, oKey and oValid update one cycle after the frame-complete tick that triggers the accept.
- Accept latency from a clean press: at most (P_DEBOUNCE+1) frames plus 1 cycle. The first, partial frame may miss the key.
- Column inputs must settle within P_TICK_DIV-3 cycles of a row change (two synchronizer cycles plus the sample cycle).

## Test plan
Benches run with P_TICK_DIV=4 and P_DEBOUNCE=2. The keypad model pulls iCol[c] low while oRow[r] is low for each pressed key (r,c).
- Reset and scan: release rst. oRow=1110, oData=0 and oValid=0 at reset; oRow then steps 1101, 1011, 0111, 1110 at 4-cycle intervals.
- Single press: hold (1,2) for 4 frames, then release for 3 frames. Exactly one accept: oKey=6, oData=0x00000006, oValid=1. Then type A and B the same way: oData=0x000006AB.
- Rejects: a key present for only 1 frame gives no accept. Keys 5 and 9 held together for 5 frames give no accept (MULTI). Holding 6 for 10 frames gives one accept only.
- Rollover: type keys 1 through 9 in sequence. oData=0x23456789, oKey=9.
- Strobes:
  - iRe one cycle after an accept gives oValid=0 on the next cycle.
  - iRe in the same cycle as an accept gives oValid=1.
  - iClr in the same cycle as an accept of key 7 gives oData=0x00000007.
- Reset mid-hold: with key 3 in HELD, pulse rst while keeping the key held. All outputs return to reset values; oKey=3 and oValid=1 reappear 2-3 frames later.
